// File: rtl/io_port_bridge.sv
// Peripheral endpoint of the processor IO port at address 255: a TX FIFO for
// processor stores and an RX FIFO whose head feeds the processor's IO input.
module io_port_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] cpu_wr_data,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  output logic [WIDTH-1:0] cpu_rd_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear_flags,
  output logic             tx_overrun,
  output logic             rx_underrun,
  output logic [CW-1:0]    tx_count,
  output logic [CW-1:0]    rx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    tx_rd_ptr, tx_wr_ptr;
  logic [AW-1:0]    rx_rd_ptr, rx_wr_ptr;
  logic             tx_push, tx_pop, tx_drop;
  logic             rx_push, rx_pop, rx_miss;

  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] count,
                                               input logic push,
                                               input logic pop);
    if (push && !pop) return count + CW'(1);
    if (pop && !push) return count - CW'(1);
    return count;
  endfunction

  // A full TX still accepts a store when the consumer drains a word in the
  // same cycle; RX offers no such pass-through so in_ready stays registered.
  always_comb begin
    out_valid   = (tx_count != '0);
    out_data    = out_valid ? tx_mem[tx_rd_ptr] : '0;
    tx_pop      = out_valid && out_ready;
    tx_push     = cpu_wr && ((tx_count != FULL) || tx_pop);
    tx_drop     = cpu_wr && !tx_push;
    in_ready    = (rx_count != FULL) && !reset;
    rx_push     = in_valid && in_ready;
    rx_pop      = cpu_rd && (rx_count != '0);
    rx_miss     = cpu_rd && (rx_count == '0);
    cpu_rd_data = (rx_count != '0) ? rx_mem[rx_rd_ptr] : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_rd_ptr   <= '0;
      tx_wr_ptr   <= '0;
      tx_count    <= '0;
      rx_rd_ptr   <= '0;
      rx_wr_ptr   <= '0;
      rx_count    <= '0;
      tx_overrun  <= 1'b0;
      rx_underrun <= 1'b0;
    end else begin
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      tx_count <= next_count(tx_count, tx_push, tx_pop);
      rx_count <= next_count(rx_count, rx_push, rx_pop);
      if (clear_flags) begin
        tx_overrun  <= 1'b0;
        rx_underrun <= 1'b0;
      end else begin
        if (tx_drop) tx_overrun  <= 1'b1;
        if (rx_miss) rx_underrun <= 1'b1;
      end
    end
  end

  // Storage is data-only; stale entries are unreachable once pointers reset.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= cpu_wr_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= in_data;
  end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Peripheral-side endpoint of the processor's memory-mapped IO port at address 255.
- Processor stores to address 255 are captured into a TX FIFO and drained to an external consumer over a valid/ready handshake.
- Data from an external producer is buffered in an RX FIFO. Its head is presented to the processor's IO input word, and each processor load from address 255 pops it.
- Sits between ProcessorSansControl (io_out/io_in plus decoded strobes) and board-level devices.

Parameters:
- WIDTH, 16, data word width; matches the processor datapath.
- DEPTH, 4, entries per FIFO; must be a power of two, 2 or greater.
- CW, $clog2(DEPTH)+1, width of the count outputs (derived; do not override).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_wr_data  in  WIDTH  processor IO output word (io_out).
- cpu_wr  in  1  one-cycle strobe: processor store to address 255 this cycle.
- cpu_rd  in  1  one-cycle strobe: processor load from address 255 this cycle.
- cpu_rd_data  out  WIDTH  word for processor io_in; RX FIFO head.
- out_data  out  WIDTH  TX FIFO head to the external consumer.
- out_valid  out  1  TX FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- in_data  in  WIDTH  external producer word.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  RX FIFO can accept a word.
- clear_flags  in  1  synchronous clear of the sticky error flags.
- tx_overrun  out  1  sticky: cpu_wr was dropped because TX was full.
- rx_underrun  out  1  sticky: cpu_rd occurred while RX was empty.
- tx_count  out  CW  TX occupancy, 0..DEPTH.
- rx_count  out  CW  RX occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, immediate):
  - All pointers and counts go to 0; tx_overrun and rx_underrun go to 0.
  - out_valid=0, in_ready=0 while reset is high; in_ready=1 from the first cycle after release.
  - cpu_rd_data=0 and out_data=0. FIFO storage contents need not be cleared.
  - Reset mid-transfer discards all buffered words; no partial handshake completes.
- Each FIFO is circular with read and write pointers wrapping modulo DEPTH and a CW-bit count. Full is count==DEPTH; empty is count==0.
- TX push: on cpu_wr.
  - Accepted if tx_count<DEPTH, or if a TX pop happens in the same cycle (full plus simultaneous pop: push accepted, count unchanged).
  - Otherwise the word is dropped and tx_overrun is set.
- TX pop: occurs when out_valid && out_ready.
  - out_valid = (tx_count!=0).
  - out_data = word at the TX read pointer when non-empty, 0 when empty (combinational).
  - out_data and out_valid stay stable until the pop.
- TX latency: a word pushed at edge N is visible on out_valid/out_data after edge N, including when the FIFO was empty. There is no bypass within the same cycle.
- RX push: occurs when in_valid && in_ready.
  - in_ready = (rx_count<DEPTH) && !reset. There is no full-plus-pop pass-through; in_ready depends only on registered count.
- RX pop: on cpu_rd when rx_count!=0.
  - cpu_rd_data = RX head when non-empty, else 0 (combinational), so the processor samples it in the same cycle as cpu_rd.
  - cpu_rd with RX empty: no pointer change, rx_underrun is set, cpu_rd_data stays 0.
- Simultaneous push and pop on one FIFO: both pointers advance and the count is unchanged. This is legal at any occupancy allowed by the rules above.
- Flags: clear_flags takes priority over a set event in the same cycle. A set in the cycle after the clear is recorded.
- cpu_wr and cpu_rd in the same cycle are independent; both are honored.
- Counts never exceed DEPTH or go below 0 under any input combination.

Test Plan:
- Reset, then cpu_wr 0x1234, 0xBEEF, 0x0001 with out_ready=0 -> tx_count=3, out_valid=1, out_data=0x1234. Then out_ready=1 -> out_data is 0x1234, 0xBEEF, 0x0001 on consecutive cycles, then out_valid=0.
- Five cpu_wr (0x0A..0x0E) with out_ready=0 and DEPTH=4 -> tx_count=4, tx_overrun=1, drained order 0x0A..0x0D. Pulse clear_flags -> tx_overrun=0.
- TX full, cpu_wr 0x5555 in the same cycle as out_ready=1 -> count stays 4, 0x5555 drains last, tx_overrun stays 0.
- in_valid with 0x00FF, 0x7F00 -> rx_count=2, cpu_rd_data=0x00FF. cpu_rd -> cpu_rd_data=0x7F00. cpu_rd -> 0. Third cpu_rd -> rx_underrun=1, rx_count=0.
- Fill RX to 4 -> in_ready=0 and a held in_valid word is not taken. Issue cpu_rd -> in_ready=1 next cycle and the held word is accepted. Pointer wrap preserves order across at least 10 words.
- Assert reset mid-stream with tx_count=2 and rx_count=3 -> all counts 0, out_valid=0, in_ready=0 immediately. After release in_ready=1 and flags are 0.
